// File: rtl/cache_hierarchy.sv
// L1/L2 tag-compare and hit/miss decision stage for a byte-wide memory path.
// Combinational compare against externally supplied line state; one-cycle registered result.
module cache_hierarchy #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 8,
   parameter int OFFSET_BITS = 2,
   parameter int L1_INDEX    = 6,
   parameter int L2_INDEX    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read_write,
   input  logic [DATA_W-1:0] data_in,
   input  logic              l1_valid,
   input  logic [ADDR_W-1:0] l1_stored_tag,
   input  logic [DATA_W-1:0] l1_data,
   input  logic              l2_valid,
   input  logic [ADDR_W-1:0] l2_stored_tag,
   input  logic [DATA_W-1:0] l2_data,
   output logic              l1_hit,
   output logic              l1_miss,
   output logic              l2_hit,
   output logic              l2_miss,
   output logic [DATA_W-1:0] data_out,
   output logic              memory_access
);

   localparam int L1_SHIFT = OFFSET_BITS + L1_INDEX;
   localparam int L2_SHIFT = OFFSET_BITS + L2_INDEX;

   // Right shift leaves the tag zero-extended to the full stored-tag width.
   function automatic logic [ADDR_W-1:0] extract_tag(input logic [ADDR_W-1:0] addr,
                                                     input int              shift);
      return addr >> shift;
   endfunction

   logic [ADDR_W-1:0] l1_tag_p0;
   logic [ADDR_W-1:0] l2_tag_p0;
   logic              l1_match_p0;
   logic              l2_match_p0;
   logic [DATA_W-1:0] data_sel_p0;

   logic              l1_hit_p1;
   logic              l1_miss_p1;
   logic              l2_hit_p1;
   logic              l2_miss_p1;
   logic              mem_acc_p1;
   logic [DATA_W-1:0] data_out_p1;

   // Stage p0: tag extraction, compare and return-data select
   assign l1_tag_p0   = extract_tag(address, L1_SHIFT);
   assign l2_tag_p0   = extract_tag(address, L2_SHIFT);
   assign l1_match_p0 = l1_valid & (l1_tag_p0 == l1_stored_tag);
   assign l2_match_p0 = l2_valid & (l2_tag_p0 == l2_stored_tag);

   always_comb begin
      data_sel_p0 = '0;
      if (read_write) begin
         data_sel_p0 = data_in;
      end else if (l1_match_p0) begin
         data_sel_p0 = l1_data;
      end else if (l2_match_p0) begin
         data_sel_p0 = l2_data;
      end
   end

   // Stage p1: registered decision; reset also drops the in-flight lookup
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         l1_hit_p1   <= 1'b0;
         l1_miss_p1  <= 1'b0;
         l2_hit_p1   <= 1'b0;
         l2_miss_p1  <= 1'b0;
         mem_acc_p1  <= 1'b0;
         data_out_p1 <= '0;
      end else begin
         l1_hit_p1   <= l1_match_p0;
         l1_miss_p1  <= ~l1_match_p0;
         l2_hit_p1   <= ~l1_match_p0 & l2_match_p0;
         l2_miss_p1  <= ~l1_match_p0 & ~l2_match_p0;
         mem_acc_p1  <= ~l1_match_p0 & ~l2_match_p0;
         data_out_p1 <= data_sel_p0;
      end
   end

   assign l1_hit        = l1_hit_p1;
   assign l1_miss       = l1_miss_p1;
   assign l2_hit        = l2_hit_p1;
   assign l2_miss       = l2_miss_p1;
   assign memory_access = mem_acc_p1;
   assign data_out      = data_out_p1;

endmodule

// File: tb/tb_cache_hierarchy.sv
// Self-checking bench for cache_hierarchy: directed cases plus randomized lookups
// compared against a behavioural reference model.
module tb_cache_hierarchy;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic        read_write;
   logic [7:0]  data_in;
   logic        l1_valid;
   logic [31:0] l1_stored_tag;
   logic [7:0]  l1_data;
   logic        l2_valid;
   logic [31:0] l2_stored_tag;
   logic [7:0]  l2_data;
   logic        l1_hit, l1_miss, l2_hit, l2_miss, memory_access;
   logic [7:0]  data_out;

   int checks = 0;
   int errors = 0;

   cache_hierarchy dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .address       (address),
      .read_write    (read_write),
      .data_in       (data_in),
      .l1_valid      (l1_valid),
      .l1_stored_tag (l1_stored_tag),
      .l1_data       (l1_data),
      .l2_valid      (l2_valid),
      .l2_stored_tag (l2_stored_tag),
      .l2_data       (l2_data),
      .l1_hit        (l1_hit),
      .l1_miss       (l1_miss),
      .l2_hit        (l2_hit),
      .l2_miss       (l2_miss),
      .data_out      (data_out),
      .memory_access (memory_access)
   );

   always #5 clk = ~clk;

   // Packed view: {l1_hit, l1_miss, l2_hit, l2_miss, memory_access, data_out}
   function automatic logic [12:0] observed();
      return {l1_hit, l1_miss, l2_hit, l2_miss, memory_access, data_out};
   endfunction

   // Reference model: tags by integer division (4-byte blocks; 64 L1 sets, 256 L2 sets).
   function automatic logic [12:0] model(input logic [31:0] addr, input logic rw,
                                         input logic [7:0] din,
                                         input logic v1, input logic [31:0] t1, input logic [7:0] d1,
                                         input logic v2, input logic [31:0] t2, input logic [7:0] d2);
      logic [31:0] tag1, tag2;
      tag1 = addr / 32'd256;
      tag2 = addr / 32'd1024;
      if (v1 && t1 == tag1)
         return {5'b10000, rw ? din : d1};
      else if (v2 && t2 == tag2)
         return {5'b01100, rw ? din : d2};
      else
         return {5'b01011, rw ? din : 8'h00};
   endfunction

   task automatic drive(input logic [31:0] a, input logic rw, input logic [7:0] din,
                        input logic v1, input logic [31:0] t1, input logic [7:0] d1,
                        input logic v2, input logic [31:0] t2, input logic [7:0] d2);
      address = a; read_write = rw; data_in = din;
      l1_valid = v1; l1_stored_tag = t1; l1_data = d1;
      l2_valid = v2; l2_stored_tag = t2; l2_data = d2;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(32'h10, 1'b0, 8'h00, 1'b1, 32'h0, 8'hAA, 1'b1, 32'h0, 8'hBB);
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (observed() !== 13'h0) begin
         errors++;
         $display("FAIL reset: got %h expected %h", observed(), 13'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] a [5]  = '{32'h10, 32'h20, 32'h40, 32'h50, 32'h60};
      logic        rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0]  di [5] = '{8'h00, 8'h00, 8'h00, 8'hCC, 8'h00};
      logic        v1 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] t1 [5] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF};
      logic [7:0]  d1 [5] = '{8'hAA, 8'h11, 8'h22, 8'hDD, 8'h33};
      logic        v2 [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] t2 [5] = '{32'h5, 32'h0, 32'h1, 32'h7, 32'h0};
      logic [7:0]  d2 [5] = '{8'h44, 8'hBB, 8'h55, 8'h66, 8'hFF};
      logic [12:0] req[5] = '{{5'b10000, 8'hAA}, {5'b01100, 8'hBB}, {5'b01011, 8'h00},
                              {5'b10000, 8'hCC}, {5'b01100, 8'hFF}};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(a[i], rw[i], di[i], v1[i], t1[i], d1[i], v2[i], t2[i], d2[i]);
         @(posedge clk); #1;
         checks++;
         if (observed() !== req[i]) begin
            errors++;
            $display("FAIL directed_%0d: got %h expected %h", i, observed(), req[i]);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [12:0] exp;
      // L1 invalid with matching tag, L2 also invalid-but-matching: full miss.
      @(negedge clk);
      drive(32'hFFFFFFFF, 1'b0, 8'h12, 1'b0, 32'h00FFFFFF, 8'h34, 1'b0, 32'h003FFFFF, 8'h56);
      exp = {5'b01011, 8'h00};
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL invalid_match: got %h expected %h", observed(), exp);
      end
      // L1 hit at the top of the address space; L2 inputs say match but are ignored.
      @(negedge clk);
      drive(32'hFFFFFFFF, 1'b0, 8'h12, 1'b1, 32'h00FFFFFF, 8'h34, 1'b1, 32'h003FFFFF, 8'h56);
      exp = {5'b10000, 8'h34};
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL top_addr_hit: got %h expected %h", observed(), exp);
      end
      // Write miss in both levels: memory access, data echoes input.
      @(negedge clk);
      drive(32'h8000_0400, 1'b1, 8'h9C, 1'b1, 32'h0, 8'h34, 1'b1, 32'h0, 8'h56);
      exp = {5'b01011, 8'h9C};
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL write_miss: got %h expected %h", observed(), exp);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, t1, t2;
      logic        rw, v1, v2;
      logic [7:0]  di, d1, d2;
      logic [12:0] exp;
      for (int i = 0; i < 200; i++) begin
         a  = $urandom;
         rw = 1'($urandom_range(0, 1));
         di = 8'($urandom);
         d1 = 8'($urandom);
         d2 = 8'($urandom);
         v1 = 1'($urandom_range(0, 1));
         v2 = 1'($urandom_range(0, 1));
         t1 = ($urandom_range(0, 2) != 0) ? a / 32'd256  : $urandom;
         t2 = ($urandom_range(0, 2) != 0) ? a / 32'd1024 : (a / 32'd1024) ^ (32'd1 << $urandom_range(0, 31));
         exp = model(a, rw, di, v1, t1, d1, v2, t2, d2);
         @(negedge clk);
         drive(a, rw, di, v1, t1, d1, v2, t2, d2);
         @(posedge clk); #1;
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("FAIL random_%0d addr=%h: got %h expected %h", i, a, observed(), exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] exp;
      // Hit then immediate reset: lookup in flight at the reset edge is dropped.
      @(negedge clk);
      drive(32'h0000_1234, 1'b0, 8'h00, 1'b1, 32'h12, 8'h5A, 1'b0, 32'h0, 8'h00);
      exp = {5'b10000, 8'h5A};
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL pre_reset_hit: got %h expected %h", observed(), exp);
      end
      @(negedge clk);
      rst_n = 1'b0;
      drive(32'h0000_1234, 1'b1, 8'hE7, 1'b1, 32'h12, 8'h5A, 1'b0, 32'h0, 8'h00);
      @(posedge clk); #1;
      checks++;
      if (observed() !== 13'h0) begin
         errors++;
         $display("FAIL midstream_reset: got %h expected %h", observed(), 13'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp = {5'b10000, 8'hE7};
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL post_reset_write: got %h expected %h", observed(), exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'h0, 1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h00);
      test_reset();
      test_directed();
      test_boundaries();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
